// File: rtl/rr_mux_arbiter_pkg.sv
// Shared constants, types and helpers for the round-robin
// arbiter in front of the 4:1 word multiplexer.
package rr_mux_arbiter_pkg;

    localparam int NCH   = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } slot_state_t;

    function automatic logic [SEL_W-1:0] next_ptr(
        input logic [SEL_W-1:0] ch
    );
        return ch + 2'd1;
    endfunction

    function automatic logic [SEL_W-1:0] rr_winner(
        input logic [NCH-1:0]   req,
        input logic [SEL_W-1:0] ptr
    );
        logic [SEL_W-1:0] w_idx;
        logic [SEL_W-1:0] w_win;
        logic             w_found;
        w_win   = ptr;
        w_found = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            w_idx = ptr + SEL_W'(k);
            if (!w_found && req[w_idx]) begin
                w_win   = w_idx;
                w_found = 1'b1;
            end
        end
        return w_win;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_mux.sv
// Parameterised 4:1 word multiplexer; slice i of x is
// selected when s == i.
module word_mux4 #(
    parameter int N = 4
) (
    input  logic [4*N-1:0] i_x,
    input  logic [1:0]     i_s,
    output logic [N-1:0]   o_y
);

    assign o_y = i_x[i_s*N +: N];

endmodule

// File: rtl/rr_mux_arbiter_pick4.sv
// Combinational round-robin pick: first requesting channel
// at or after the priority pointer.
module rr_pick4
    import rr_mux_arbiter_pkg::*;
(
    input  logic [NCH-1:0]   i_req,
    input  logic [SEL_W-1:0] i_ptr,
    output logic [SEL_W-1:0] o_winner,
    output logic             o_any_req
);

    assign o_winner  = rr_winner(i_req, i_ptr);
    assign o_any_req = |i_req;

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving the word MUX select and a
// single-entry valid/ready output buffer with a word counter.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   req,
    input  logic [4*N-1:0]   x,
    output logic [NCH-1:0]   ack,
    output logic [SEL_W-1:0] sel,
    output logic [N-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] word_cnt
);

    slot_state_t      r_state;
    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] r_sel;
    logic [NCH-1:0]   r_ack;
    logic [N-1:0]     r_data;
    logic [CNT_W-1:0] r_cnt;

    logic [SEL_W-1:0] w_win;
    logic             w_any;
    logic [N-1:0]     w_word;
    logic             w_full;
    logic             w_slot_free;
    logic             w_grant;
    logic             w_accept;

    rr_pick4 u_pick (
        .i_req     (req),
        .i_ptr     (r_ptr),
        .o_winner  (w_win),
        .o_any_req (w_any)
    );

    // The winner index drives the same MUX as downstream,
    // so slice ordering is identical.
    word_mux4 #(.N(N)) u_mux (
        .i_x (x),
        .i_s (w_win),
        .o_y (w_word)
    );

    assign w_full      = (r_state == S_FULL);
    assign w_slot_free = !w_full || out_ready;
    assign w_grant     = w_slot_free && w_any;
    assign w_accept    = w_full && out_ready;

    // Slot state, capture of the granted word and pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
            r_ptr   <= '0;
            r_sel   <= '0;
            r_ack   <= '0;
            r_data  <= '0;
        end else begin
            r_ack <= '0;
            if (w_grant) begin
                r_state <= S_FULL;
                r_data  <= w_word;
                r_sel   <= w_win;
                r_ack   <= NCH'(1) << w_win;
                r_ptr   <= next_ptr(w_win);
            end else if (out_ready) begin
                r_state <= S_EMPTY;
            end
        end
    end

    // Delivered-word counter, wraps silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign ack       = r_ack;
    assign sel       = r_sel;
    assign out_data  = r_data;
    assign out_valid = w_full;
    assign word_cnt  = r_cnt;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: directed plan
// followed by randomized traffic against a reference model.
module tb_rr_mux_arbiter;

    localparam int N     = 4;
    localparam int CNT_W = 4;

    logic          clk;
    logic          rst;
    logic [3:0]    req;
    logic [4*N-1:0] x;
    logic [3:0]    ack;
    logic [1:0]    sel;
    logic [N-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic [CNT_W-1:0] word_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state (value after the next edge)
    int m_valid = 0;
    int m_data  = 0;
    int m_sel   = 0;
    int m_ptr   = 0;
    int m_cnt   = 0;
    int m_ack   = 0;

    int exp_sel[$];
    int exp_data[$];

    localparam logic [15:0] XP = 16'hDCBA;

    rr_mux_arbiter #(.N(N), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .x         (x),
        .ack       (ack),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .word_cnt  (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Advance the model by one edge using the rules directly.
    task automatic model(input bit r, input logic [3:0] rq,
                         input logic [15:0] xx, input bit rdy);
        int c;
        bit found;
        if (r) begin
            m_valid = 0; m_data = 0; m_sel = 0;
            m_ptr = 0; m_cnt = 0; m_ack = 0;
            return;
        end
        if (m_valid == 1 && rdy)
            m_cnt = (m_cnt + 1) % (1 << CNT_W);
        m_ack = 0;
        found = 0;
        if (m_valid == 0 || rdy) begin
            for (int k = 0; k < 4; k++) begin
                c = (m_ptr + k) % 4;
                if (!found && rq[c]) begin
                    found   = 1;
                    m_sel   = c;
                    m_data  = (xx >> (4 * c)) & 15;
                    m_valid = 1;
                    m_ack   = 1 << c;
                    m_ptr   = (c + 1) % 4;
                    exp_sel.push_back(c);
                    exp_data.push_back(m_data);
                end
            end
            if (!found && rdy) m_valid = 0;
        end
    endtask

    task automatic step(input bit r, input logic [3:0] rq,
                        input logic [15:0] xx, input bit rdy);
        @(negedge clk);
        rst = r; req = rq; x = xx; out_ready = rdy;
        model(r, rq, xx, rdy);
        @(posedge clk);
        #1;
    endtask

    // Monitor: per-cycle state checks; scoreboard pop on ack.
    initial begin
        int es, ed;
        forever begin
            @(posedge clk);
            #1;
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("word_cnt", 32'(word_cnt), 32'(m_cnt));
            chk("ack", 32'(ack), 32'(m_ack));
            chk("out_data", 32'(out_data), 32'(m_data));
            if (ack != 4'b0) begin
                if (exp_sel.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_empty: ack %0h with no expected word",
                             ack);
                end else begin
                    es = exp_sel.pop_front();
                    ed = exp_data.pop_front();
                    chk("sb_sel", 32'(sel), 32'(es));
                    chk("sb_data", 32'(out_data), 32'(ed));
                end
            end
        end
    end

    initial begin
        logic [3:0] rrq;
        logic [15:0] rx;
        logic [3:0] exp_rr;
        rst = 1'b1; req = 4'hF; x = XP; out_ready = 1'b1;

        // reset with requests pending
        step(1, 4'hF, XP, 1);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_sel", 32'(sel), 0);
        step(1, 4'hF, XP, 1);
        chk("rst_cnt", 32'(word_cnt), 0);
        chk("rst_ack", 32'(ack), 0);

        // single request
        step(0, 4'b0100, XP, 1);
        chk("single_ack", 32'(ack), 32'h4);
        chk("single_sel", 32'(sel), 2);
        chk("single_data", 32'(out_data), 32'hC);
        step(0, 4'b0000, XP, 1);
        chk("single_cnt", 32'(word_cnt), 1);
        chk("single_empty", 32'(out_valid), 0);

        // round robin over all channels
        step(1, 4'h0, XP, 1);
        for (int i = 0; i < 5; i++) begin
            step(0, 4'hF, XP, 1);
            exp_rr = 4'(10 + (i % 4));
            chk("rr_sel", 32'(sel), 32'(i % 4));
            chk("rr_data", 32'(out_data), 32'(exp_rr));
        end
        step(0, 4'h0, XP, 1);
        chk("rr_cnt", 32'(word_cnt), 5);

        // stall holds word, then back-to-back capture
        step(1, 4'h0, XP, 1);
        step(0, 4'b0010, XP, 1);
        chk("stall_cap", 32'(out_data), 32'hB);
        for (int i = 0; i < 3; i++) begin
            step(0, 4'b1000, XP, 0);
            chk("stall_hold", 32'(out_data), 32'hB);
            chk("stall_ack", 32'(ack), 0);
        end
        step(0, 4'b1000, XP, 1);
        chk("stall_next", 32'(out_data), 32'hD);
        chk("stall_sel", 32'(sel), 3);
        step(0, 4'h0, XP, 1);

        // pointer skip: ptr=2 wraps to channel 0
        step(1, 4'h0, XP, 1);
        step(0, 4'b0010, XP, 1);
        step(0, 4'b0011, XP, 1);
        chk("skip_sel", 32'(sel), 0);
        step(0, 4'b0011, XP, 1);
        chk("skip_ptr1", 32'(sel), 1);
        step(0, 4'h0, XP, 1);

        // reset while a word is stalled
        step(1, 4'h0, XP, 1);
        step(0, 4'b0001, XP, 0);
        chk("mid_full", 32'(out_valid), 1);
        step(1, 4'b0001, XP, 0);
        chk("mid_valid", 32'(out_valid), 0);
        chk("mid_cnt", 32'(word_cnt), 0);

        // counter wrap after 17 accepts
        step(1, 4'h0, XP, 1);
        for (int i = 0; i < 17; i++) step(0, 4'hF, XP, 1);
        step(0, 4'h0, XP, 1);
        chk("wrap_cnt", 32'(word_cnt), 1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            rrq = 4'($urandom_range(0, 15));
            rx  = 16'($urandom);
            step(($urandom_range(0, 39) == 0), rrq, rx,
                 ($urandom_range(0, 9) < 7));
        end
        step(0, 4'h0, XP, 1);
        step(0, 4'h0, XP, 1);
        chk("sb_drained", 32'(exp_sel.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
